// File: rtl/buffer_pixeles_mem_fifo.sv
// Word-in / pixel-out show-ahead FIFO: stores 32-bit words of 4 packed pixels and
// presents them one byte at a time, MSB first, with flow-control flags on both sides.
module buffer_pixeles_mem_fifo #(
    parameter int WORD_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memory_data,
    input  logic        save_mem_data,
    input  logic        read_pixel,
    output logic [7:0]  pixel,
    output logic        space_available,
    output logic        data_available
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(WORD_DEPTH);

    logic [31:0]       mem_q [WORD_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]        byte_sel_q, byte_sel_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;

    logic wr_en, rd_en, word_done;
    logic [31:0] head_word;

    // Acceptance uses pre-edge occupancy: a read that frees a slot this cycle
    // does not let a write into a full FIFO, and a write into an empty FIFO
    // does not let the same-cycle read through.
    assign wr_en     = save_mem_data && (word_count_q != DEPTH_CNT);
    assign rd_en     = read_pixel && (word_count_q != '0);
    assign word_done = rd_en && (byte_sel_q == 2'd3);
    assign head_word = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        byte_sel_d   = byte_sel_q;
        word_count_d = word_count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            byte_sel_d = byte_sel_q + 2'd1;
        end
        if (word_done) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, word_done})
            2'b10:   word_count_d = word_count_q + 1'b1;
            2'b01:   word_count_d = word_count_q - 1'b1;
            default: word_count_d = word_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            byte_sel_q   <= '0;
            word_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            byte_sel_q   <= byte_sel_d;
            word_count_q <= word_count_d;
        end
    end

    // Storage has no reset; contents only matter behind a nonzero word_count.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem_q[wr_ptr_q] <= memory_data;
        end
    end

    always_comb begin
        pixel = 8'h00;
        if (word_count_q != '0) begin
            case (byte_sel_q)
                2'd0:    pixel = head_word[31:24];
                2'd1:    pixel = head_word[23:16];
                2'd2:    pixel = head_word[15:8];
                default: pixel = head_word[7:0];
            endcase
        end
    end

    assign space_available = (word_count_q < DEPTH_CNT);
    assign data_available  = (word_count_q != '0);

endmodule

// File: tb/tb_buffer_pixeles_mem_fifo.sv
// Directed bench for buffer_pixeles_mem_fifo: reset, single word, full/drop,
// partial-word freeing, concurrent write/read with wrap, empty read and mid reset.
module tb_buffer_pixeles_mem_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memory_data;
    logic        save_mem_data;
    logic        read_pixel;
    logic [7:0]  pixel;
    logic        space_available;
    logic        data_available;

    int vectors = 0;
    int miscompares = 0;

    buffer_pixeles_mem_fifo #(.WORD_DEPTH(4), .ADDR_W(2)) dut (
        .clk(clk),
        .reset(reset),
        .memory_data(memory_data),
        .save_mem_data(save_mem_data),
        .read_pixel(read_pixel),
        .pixel(pixel),
        .space_available(space_available),
        .data_available(data_available)
    );

    always #5 clk = ~clk;

    // Apply one rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [7:0] px, input logic da, input logic sa);
        chk({tag, ".pixel"}, {24'h0, pixel}, {24'h0, px});
        chk({tag, ".data_available"}, {31'h0, data_available}, {31'h0, da});
        chk({tag, ".space_available"}, {31'h0, space_available}, {31'h0, sa});
    endtask

    task automatic write_word(input logic [31:0] w);
        memory_data   = w;
        save_mem_data = 1'b1;
        step();
        save_mem_data = 1'b0;
    endtask

    // Check the head pixel against the expected byte, then pop it.
    task automatic pop_expect(input string tag, input logic [31:0] w, input int k);
        logic [7:0] b;
        b = w[31-8*k -: 8];
        chk(tag, {24'h0, pixel}, {24'h0, b});
        read_pixel = 1'b1;
        step();
        read_pixel = 1'b0;
    endtask

    logic [31:0] words [4];
    logic [31:0] cwords [3];

    initial begin
        reset = 1'b0; memory_data = '0; save_mem_data = 1'b0; read_pixel = 1'b0;
        #1;
        step();
        step();
        chk_flags("reset", 8'h00, 1'b0, 1'b1);

        reset = 1'b1;
        write_word(32'hAABBCCDD);
        chk_flags("single_wr", 8'hAA, 1'b1, 1'b1);
        read_pixel = 1'b1;
        step(); chk("single_b1", {24'h0, pixel}, 32'hBB);
        step(); chk("single_b2", {24'h0, pixel}, 32'hCC);
        step(); chk("single_b3", {24'h0, pixel}, 32'hDD);
        step();
        read_pixel = 1'b0;
        chk_flags("single_empty", 8'h00, 1'b0, 1'b1);

        words[0] = 32'h11223344; words[1] = 32'h55667788;
        words[2] = 32'h99AABBCC; words[3] = 32'hDDEEFF00;
        for (int i = 0; i < 4; i++) write_word(words[i]);
        chk_flags("full", 8'h11, 1'b1, 1'b0);
        write_word(32'h87654321);
        chk_flags("full_drop", 8'h11, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                pop_expect($sformatf("full_rd_w%0d_b%0d", i, k), words[i], k);
                if (i == 0 && k < 3)
                    chk($sformatf("partial_space_b%0d", k), {31'h0, space_available}, 32'h0);
            end
            if (i == 0) chk("word_freed_space", {31'h0, space_available}, 32'h1);
        end
        chk_flags("drained", 8'h00, 1'b0, 1'b1);

        // One word stored, then 4 cycles of concurrent write+read; the 4th write
        // meets a full FIFO and is dropped even though a word is freed that edge.
        write_word(32'hC0C1C2C3);
        cwords[0] = 32'hA1A2A3A4; cwords[1] = 32'hB1B2B3B4; cwords[2] = 32'hD1D2D3D4;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] w;
            w = 32'hC0C1C2C3;
            chk($sformatf("conc_b%0d", k), {24'h0, pixel}, {24'h0, w[31-8*k -: 8]});
            memory_data   = (k < 3) ? cwords[k] : 32'hEEEEEEEE;
            save_mem_data = 1'b1;
            read_pixel    = 1'b1;
            step();
        end
        save_mem_data = 1'b0;
        read_pixel    = 1'b0;
        chk_flags("conc_after", 8'hA1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++)
                pop_expect($sformatf("conc_rd_w%0d_b%0d", i, k), cwords[i], k);
        chk_flags("conc_drained", 8'h00, 1'b0, 1'b1);

        read_pixel = 1'b1;
        step();
        read_pixel = 1'b0;
        chk_flags("empty_read", 8'h00, 1'b0, 1'b1);

        memory_data = 32'h0A0B0C0D; save_mem_data = 1'b1; read_pixel = 1'b1;
        step();
        save_mem_data = 1'b0; read_pixel = 1'b0;
        chk_flags("empty_wr_rd", 8'h0A, 1'b1, 1'b1);
        read_pixel = 1'b1;
        step(); step();
        read_pixel = 1'b0;
        chk("mid_b2", {24'h0, pixel}, 32'h0C);
        reset = 1'b0;
        step();
        chk_flags("mid_reset", 8'h00, 1'b0, 1'b1);
        reset = 1'b1;
        write_word(32'h12345678);
        chk_flags("post_reset_wr", 8'h12, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
